// File: rtl/fwd_ctrl_pkg.sv
// fwd_ctrl_pkg
// Shared definitions for the EX-stage forwarding controller and the ALU:
// operand select encodings, the controller FSM state encoding and the
// pipeline-slot record used to track producers in EX and MEM.
package fwd_ctrl_pkg;

  // Register index width carried in the tracking slots. The top-level
  // REG_W parameter defaults to this value and must agree with it.
  localparam int REG_IDX_W = 5;

  // Operand A select (shared with the ALU)
  localparam logic [1:0] A_SEL_RS1      = 2'b00;
  localparam logic [1:0] A_SEL_PC       = 2'b01;
  localparam logic [1:0] A_SEL_NEXT     = 2'b10;  // MEM-stage result
  localparam logic [1:0] A_SEL_NEXTNEXT = 2'b11;  // WB-stage result

  // Operand B select (shared with the ALU)
  localparam logic [1:0] B_SEL_RS2      = 2'b00;
  localparam logic [1:0] B_SEL_IMM      = 2'b01;
  localparam logic [1:0] B_SEL_NEXT     = 2'b10;
  localparam logic [1:0] B_SEL_NEXTNEXT = 2'b11;

  // Forwarding result for a single source operand; same codes as above.
  localparam logic [1:0] FWD_NONE     = 2'b00;
  localparam logic [1:0] FWD_NEXT     = 2'b10;
  localparam logic [1:0] FWD_NEXTNEXT = 2'b11;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } fsm_state_e;

  // Producer record for one pipeline stage.
  typedef struct packed {
    logic                 vld;
    logic [REG_IDX_W-1:0] rd;
    logic                 wen;
    logic                 load;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '0;

endpackage

// File: rtl/fwd_ctrl_match.sv
// fwd_ctrl_match
// Combinational comparator for one source operand against the producers
// currently held in EX and MEM. The nearer producer (EX) wins.
//
// Ports:
//   use_src  in   operand is actually read by the instruction
//   src      in   source register index
//   ex_vld/ex_wen/ex_rd     in  EX-slot producer
//   mem_vld/mem_wen/mem_rd  in  MEM-slot producer
//   sel      out  FWD_NONE / FWD_NEXT / FWD_NEXTNEXT
//   hit_ex   out  operand depends on the instruction in EX
module fwd_ctrl_match
  import fwd_ctrl_pkg::*;
#(
  parameter int REG_W = REG_IDX_W
) (
  input  logic             use_src,
  input  logic [REG_W-1:0] src,
  input  logic             ex_vld,
  input  logic             ex_wen,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             mem_vld,
  input  logic             mem_wen,
  input  logic [REG_W-1:0] mem_rd,
  output logic [1:0]       sel,
  output logic             hit_ex
);

  logic src_nz;
  logic hit_mem;

  // x0 is hard-wired zero and is never forwarded.
  assign src_nz  = (src != '0);
  assign hit_ex  = use_src & src_nz & ex_vld  & ex_wen  & (ex_rd  == src);
  assign hit_mem = use_src & src_nz & mem_vld & mem_wen & (mem_rd == src);

  always_comb begin
    sel = FWD_NONE;
    if (hit_ex) begin
      sel = FWD_NEXT;
    end else if (hit_mem) begin
      sel = FWD_NEXTNEXT;
    end
  end

endmodule

// File: rtl/fwd_ctrl.sv
// fwd_ctrl
// Hazard and forwarding controller for the EX stage. Tracks the
// destination registers of the instructions in EX and MEM, computes the
// ALU operand selects and store-data select for the instruction in ID,
// and registers them into EX. Raises a one-cycle load-use stall and
// inserts a bubble into EX while ID holds.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   id_valid               ID holds a real instruction
//   id_rs1/id_rs2/id_rd    decoded register indices
//   id_use_rs1/id_use_rs2  operand is read (rs2 covers store data)
//   id_a_pc / id_b_imm     operand A is pc / operand B is imm
//   id_reg_wen             instruction writes rd
//   id_is_load             instruction is a load
//   flush                  kill the ID instruction (taken branch/jump)
//   stall                  hold PC and ID this cycle (combinational)
//   ex_valid               EX holds a real instruction
//   ex_a_sel/ex_b_sel      registered ALU operand selects
//   ex_st_sel              registered store-data select
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_RUN   | normal issue; a load-use hazard raises stall for one cycle
// ST_STALL | load has moved to MEM; held instruction issues, no stall
module fwd_ctrl
  import fwd_ctrl_pkg::*;
#(
  parameter int REG_W      = REG_IDX_W,
  parameter bit LOAD_STALL = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_a_pc,
  input  logic             id_b_imm,
  input  logic             id_reg_wen,
  input  logic             id_is_load,
  input  logic             flush,
  output logic             stall,
  output logic             ex_valid,
  output logic [1:0]       ex_a_sel,
  output logic [1:0]       ex_b_sel,
  output logic [1:0]       ex_st_sel
);

  fsm_state_e state_q, state_d;
  slot_t      ex_slot_q, ex_slot_d;
  slot_t      mem_slot_q, mem_slot_d;
  logic       ex_valid_q, ex_valid_d;
  logic [1:0] a_sel_q, a_sel_d;
  logic [1:0] b_sel_q, b_sel_d;
  logic [1:0] st_sel_q, st_sel_d;

  logic [1:0] fwd_rs1;
  logic [1:0] fwd_rs2;
  logic       hit_ex_rs1;
  logic       hit_ex_rs2;
  logic       stall_c;
  logic       take_id;

  // The MEM load flag does not affect any decision (a load in MEM is
  // forwarded like any producer); it is tracked for debug visibility.
  logic       mem_load_unused;
  assign mem_load_unused = mem_slot_q.load;

  fwd_ctrl_match #(.REG_W(REG_W)) u_match_rs1 (
    .use_src (id_use_rs1),
    .src     (id_rs1),
    .ex_vld  (ex_slot_q.vld),
    .ex_wen  (ex_slot_q.wen),
    .ex_rd   (ex_slot_q.rd),
    .mem_vld (mem_slot_q.vld),
    .mem_wen (mem_slot_q.wen),
    .mem_rd  (mem_slot_q.rd),
    .sel     (fwd_rs1),
    .hit_ex  (hit_ex_rs1)
  );

  fwd_ctrl_match #(.REG_W(REG_W)) u_match_rs2 (
    .use_src (id_use_rs2),
    .src     (id_rs2),
    .ex_vld  (ex_slot_q.vld),
    .ex_wen  (ex_slot_q.wen),
    .ex_rd   (ex_slot_q.rd),
    .mem_vld (mem_slot_q.vld),
    .mem_wen (mem_slot_q.wen),
    .mem_rd  (mem_slot_q.rd),
    .sel     (fwd_rs2),
    .hit_ex  (hit_ex_rs2)
  );

  always_comb begin
    state_d    = state_q;
    ex_slot_d  = SLOT_EMPTY;
    mem_slot_d = ex_slot_q;
    ex_valid_d = 1'b0;
    a_sel_d    = A_SEL_RS1;
    b_sel_d    = B_SEL_RS2;
    st_sel_d   = FWD_NONE;

    // Load result is not available until MEM, so a dependent instruction
    // right behind a load waits one cycle and then picks it up from WB.
    // flush wins over stall; a stall is never raised from ST_STALL, which
    // bounds it to a single cycle.
    stall_c = LOAD_STALL & id_valid & ~flush & (state_q == ST_RUN) &
              ex_slot_q.load & (hit_ex_rs1 | hit_ex_rs2);

    take_id = id_valid & ~flush & ~stall_c;

    if (take_id) begin
      ex_slot_d.vld  = 1'b1;
      ex_slot_d.rd   = id_rd;
      ex_slot_d.wen  = id_reg_wen;
      ex_slot_d.load = id_is_load;
      ex_valid_d     = 1'b1;
      a_sel_d        = id_a_pc  ? A_SEL_PC  : fwd_rs1;
      b_sel_d        = id_b_imm ? B_SEL_IMM : fwd_rs2;
      // Store data always comes through the rs2 path, even when operand B
      // is the immediate offset.
      st_sel_d       = fwd_rs2;
    end

    state_d = stall_c ? ST_STALL : ST_RUN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      ex_slot_q  <= SLOT_EMPTY;
      mem_slot_q <= SLOT_EMPTY;
      ex_valid_q <= 1'b0;
      a_sel_q    <= A_SEL_RS1;
      b_sel_q    <= B_SEL_RS2;
      st_sel_q   <= FWD_NONE;
    end else begin
      state_q    <= state_d;
      ex_slot_q  <= ex_slot_d;
      mem_slot_q <= mem_slot_d;
      ex_valid_q <= ex_valid_d;
      a_sel_q    <= a_sel_d;
      b_sel_q    <= b_sel_d;
      st_sel_q   <= st_sel_d;
    end
  end

  assign stall     = stall_c;
  assign ex_valid  = ex_valid_q;
  assign ex_a_sel  = a_sel_q;
  assign ex_b_sel  = b_sel_q;
  assign ex_st_sel = st_sel_q;

endmodule

// File: tb/tb_fwd_ctrl.sv
module tb_fwd_ctrl;

  localparam bit LOAD_STALL = 1'b1;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_use_rs1, id_use_rs2, id_a_pc, id_b_imm;
  logic       id_reg_wen, id_is_load, flush;
  logic       stall, ex_valid;
  logic [1:0] ex_a_sel, ex_b_sel, ex_st_sel;

  fwd_ctrl #(.REG_W(5), .LOAD_STALL(LOAD_STALL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .id_valid   (id_valid),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_rd      (id_rd),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .id_a_pc    (id_a_pc),
    .id_b_imm   (id_b_imm),
    .id_reg_wen (id_reg_wen),
    .id_is_load (id_is_load),
    .flush      (flush),
    .stall      (stall),
    .ex_valid   (ex_valid),
    .ex_a_sel   (ex_a_sel),
    .ex_b_sel   (ex_b_sel),
    .ex_st_sel  (ex_st_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit valid;
    int rs1, rs2, rd;
    bit u1, u2, apc, bimm, wen, load;
  } instr_t;

  // Reference model: list of what entered EX, newest first.
  // Entry 0 is now in EX, entry 1 is in MEM.
  typedef struct {
    bit vld;
    int rd;
    bit wen;
    bit load;
  } prod_t;

  prod_t  hist[$];
  bit     m_stalled_last;  // previous cycle was a stall cycle
  bit     m_stall;         // most recent predicted stall
  int     n_tests = 0;
  int     n_fail  = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic prod_t empty_prod();
    prod_t p;
    p.vld = 0; p.rd = 0; p.wen = 0; p.load = 0;
    return p;
  endfunction

  task automatic model_reset();
    hist.delete();
    hist.push_back(empty_prod());
    hist.push_back(empty_prod());
    m_stalled_last = 0;
    m_stall = 0;
  endtask

  // Newest producer of src wins; distance 1 -> 2 (next_rd), 2 -> 3.
  function automatic int mfwd(input int src, input bit use_it);
    if (!use_it || src == 0) return 0;
    for (int k = 0; k < 2; k++)
      if (hist[k].vld && hist[k].wen && hist[k].rd == src) return k + 2;
    return 0;
  endfunction

  function automatic instr_t mk(input int rd, input int rs1, input int rs2,
                                input bit u1, input bit u2, input bit apc,
                                input bit bimm, input bit wen, input bit load);
    instr_t i;
    i.valid = 1; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2;
    i.u1 = u1; i.u2 = u2; i.apc = apc; i.bimm = bimm;
    i.wen = wen; i.load = load;
    return i;
  endfunction

  function automatic instr_t alu(input int rd, input int rs1, input int rs2);
    return mk(rd, rs1, rs2, 1, 1, 0, 0, 1, 0);
  endfunction
  function automatic instr_t alui(input int rd, input int rs1);
    return mk(rd, rs1, 0, 1, 0, 0, 1, 1, 0);
  endfunction
  function automatic instr_t ld(input int rd, input int rs1);
    return mk(rd, rs1, 0, 1, 0, 0, 1, 1, 1);
  endfunction
  function automatic instr_t st(input int rs1, input int rs2);
    return mk(0, rs1, rs2, 1, 1, 0, 1, 0, 0);
  endfunction
  function automatic instr_t nop();
    return mk(0, 0, 0, 1, 0, 0, 1, 1, 0);
  endfunction

  task automatic drive(input instr_t i, input bit fl);
    id_valid   = i.valid;
    id_rs1     = 5'(i.rs1);
    id_rs2     = 5'(i.rs2);
    id_rd      = 5'(i.rd);
    id_use_rs1 = i.u1;
    id_use_rs2 = i.u2;
    id_a_pc    = i.apc;
    id_b_imm   = i.bimm;
    id_reg_wen = i.wen;
    id_is_load = i.load;
    flush      = fl;
  endtask

  // Called just after a rising edge; drives ID, checks stall mid-cycle,
  // then checks the EX outputs after the next edge.
  task automatic issue(input instr_t i, input bit fl);
    bit exp_stall, take;
    int ea, eb, es;
    prod_t p;
    drive(i, fl);
    exp_stall = LOAD_STALL && i.valid && !fl && !m_stalled_last &&
                hist[0].vld && hist[0].load && hist[0].wen && hist[0].rd != 0 &&
                ((i.u1 && i.rs1 == hist[0].rd) || (i.u2 && i.rs2 == hist[0].rd));
    take = i.valid && !fl && !exp_stall;
    ea = take ? (i.apc  ? 1 : mfwd(i.rs1, i.u1)) : 0;
    eb = take ? (i.bimm ? 1 : mfwd(i.rs2, i.u2)) : 0;
    es = take ? mfwd(i.rs2, i.u2) : 0;
    @(negedge clk);
    chk("stall", int'(stall), int'(exp_stall));
    @(posedge clk);
    #1;
    chk("ex_valid", int'(ex_valid), int'(take));
    chk("ex_a_sel", int'(ex_a_sel), ea);
    chk("ex_b_sel", int'(ex_b_sel), eb);
    chk("ex_st_sel", int'(ex_st_sel), es);
    p = empty_prod();
    if (take) begin
      p.vld = 1; p.rd = i.rd; p.wen = i.wen; p.load = i.load;
    end
    hist.push_front(p);
    void'(hist.pop_back());
    m_stalled_last = exp_stall;
    m_stall = exp_stall;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"}, int'(stall), 0);
    chk({tag, "_valid"}, int'(ex_valid), 0);
    chk({tag, "_a"}, int'(ex_a_sel), 0);
    chk({tag, "_b"}, int'(ex_b_sel), 0);
    chk({tag, "_st"}, int'(ex_st_sel), 0);
  endtask

  instr_t cur;
  instr_t idle;

  initial begin
    idle = nop();
    idle.valid = 0;
    drive(idle, 0);
    rst_n = 1'b0;
    model_reset();
    #2;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // addi x5 ; add x6,x5,x1
    issue(alui(5, 1), 0);
    issue(alu(6, 5, 1), 0);
    chk("tp1_a", int'(ex_a_sel), 2);
    chk("tp1_b", int'(ex_b_sel), 0);

    // add x5 ; nop ; sub x7,x2,x5
    issue(alu(5, 1, 2), 0);
    issue(nop(), 0);
    issue(alu(7, 2, 5), 0);
    chk("tp2_b", int'(ex_b_sel), 3);

    // writer to x0, then reader of x0
    issue(alu(0, 3, 3), 0);
    issue(nop(), 0);
    issue(alu(7, 0, 0), 0);
    chk("tp2_x0_a", int'(ex_a_sel), 0);
    chk("tp2_x0_b", int'(ex_b_sel), 0);

    // lw x5 ; add x6,x5,x5
    issue(ld(5, 1), 0);
    issue(alu(6, 5, 5), 0);
    chk("tp3_stalled", int'(m_stall), 1);
    chk("tp3_bubble", int'(ex_valid), 0);
    issue(alu(6, 5, 5), 0);
    chk("tp3_a", int'(ex_a_sel), 3);
    chk("tp3_b", int'(ex_b_sel), 3);

    // add x5 ; add x5 ; sw x5,0(x5)
    issue(alu(5, 1, 2), 0);
    issue(alu(5, 3, 4), 0);
    issue(st(5, 5), 0);
    chk("tp4_a", int'(ex_a_sel), 2);
    chk("tp4_b", int'(ex_b_sel), 1);
    chk("tp4_st", int'(ex_st_sel), 2);

    // lw x5 ; dependent add flushed where it would stall
    issue(ld(5, 1), 0);
    issue(alu(6, 5, 5), 1);
    chk("tp5_valid", int'(ex_valid), 0);
    issue(alu(8, 1, 2), 0);

    // flush arriving during the STALL state
    issue(ld(5, 1), 0);
    issue(alu(6, 5, 5), 0);
    issue(alu(6, 5, 5), 1);
    chk("tp5b_valid", int'(ex_valid), 0);
    issue(alu(9, 1, 2), 0);

    // reset pulsed during the stall cycle
    issue(ld(5, 1), 0);
    drive(alu(6, 5, 5), 0);
    @(negedge clk);
    chk("tp6_pre_stall", int'(stall), 1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("tp6_rst");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(alu(6, 5, 5), 0);
    chk("tp6_valid", int'(ex_valid), 1);

    // randomized traffic on a small register set to provoke hazards
    cur = alu(1, 2, 3);
    for (int n = 0; n < 600; n++) begin
      bit fl;
      fl = ($urandom_range(0, 9) == 0);
      if (!m_stall) begin
        cur = mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 1'($urandom), 1'($urandom), ($urandom_range(0, 4) == 0),
                 1'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom));
        cur.valid = ($urandom_range(0, 9) != 0);
      end
      issue(cur, fl);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fwd_ctrl.md
Name: fwd_ctrl

Overview:
- Hazard and forwarding controller that produces the ALU operand selects (a_sel, b_sel) and store-data select for the EX stage of the 5-stage core.
- Sits between decode (ID) and the ALU: takes decoded register indices from ID, tracks destination registers of the instructions in EX and MEM, and registers the selects into EX.
- Generates a one-cycle load-use stall and bubble.
- Operand select encoding shared with the ALU: 00 rs1/rs2, 01 pc/imm, 10 next_rd (MEM-stage result), 11 next_next_rd (WB-stage result).

Parameters:
- REG_W, 5, register index width.
- LOAD_STALL, 1, 1 = stall on load-use; 0 = no stall (load data forwarded combinationally from MEM).

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs1  in  REG_W  source 1 index.
- id_rs2  in  REG_W  source 2 index.
- id_rd  in  REG_W  destination index.
- id_use_rs1  in  1  instruction reads rs1.
- id_use_rs2  in  1  instruction reads rs2 (ALU operand or store data).
- id_a_pc  in  1  operand A is pc.
- id_b_imm  in  1  operand B is imm.
- id_reg_wen  in  1  instruction writes rd.
- id_is_load  in  1  instruction is a load.
- flush  in  1  taken branch/jump; kill ID instruction.
- stall  out  1  hold PC and ID register this cycle (combinational).
- ex_valid  out  1  EX holds a real instruction.
- ex_a_sel  out  2  ALU a_sel.
- ex_b_sel  out  2  ALU b_sel.
- ex_st_sel  out  2  store-data select: 00 rs2, 10 next_rd, 11 next_next_rd (01 unused).

Behaviour:
- Reset (async, rst_n=0): ex_valid=0, ex_a_sel=00, ex_b_sel=00, ex_st_sel=00, internal EX/MEM tracking regs cleared (valid=0, wen=0, rd=0, load=0), FSM=RUN. stall=0 while in reset.
- Internal tracking:
  - EX slot {vld, rd, wen, load} loads from ID each non-stalled edge.
  - MEM slot loads from EX slot every edge.
- Match rules (for src in {rs1, rs2}):
  - hitE = use_src & src!=0 & EX.vld & EX.wen & EX.rd==src.
  - hitM is the same test against the MEM slot.
  - x0 is never forwarded.
  - The nearer producer wins: hitE -> 10, else hitM -> 11, else 00.
- Selects registered into EX at the edge:
  - a_sel = id_a_pc ? 01 : fwd(rs1).
  - b_sel = id_b_imm ? 01 : fwd(rs2).
  - st_sel = fwd(rs2) regardless of id_b_imm.
  - Latency: one cycle from ID to ex_* outputs.
- Load-use (LOAD_STALL=1):
  - stall = id_valid & ~flush & FSM==RUN & EX.load & (hitE on rs1 or rs2).
  - While stall is high, the EX slot takes a bubble (vld=0, wen=0, selects=00) and ID holds.
  - Next cycle the load is in MEM, so the held instruction resolves to 11 (WB forward) when it enters EX.
- FSM has two states:
  - RUN -> STALL on stall=1.
  - STALL -> RUN unconditionally after one cycle; stall=0 while in STALL.
  - Stall is never longer than one cycle.
- LOAD_STALL=0: stall tied 0; a load in EX is treated like any producer.
- flush: the ID instruction is not captured; the EX slot takes a bubble. flush overrides stall. flush in STALL returns to RUN with a bubble.
- Bubble or invalid ID: ex_valid=0, all selects 00.
- A producer three ahead (in WB during ID) is not tracked. The register file is write-first, so it supplies the value.
- Reset asserted mid-stall: all state cleared immediately; no residual stall after release.

Decomposition:
- Shared package holds:
  - A_SEL_RS1/PC/NEXT/NEXTNEXT and B_SEL_RS2/IMM/NEXT/NEXTNEXT (2-bit constants, common with the ALU).
  - The FSM state encoding RUN/STALL.
  - The stage-slot struct {vld, rd, wen, load}.
- One natural sub-module: fwd_match (combinational src-vs-EX/MEM comparator returning a 2-bit select and hitE). It is instantiated for rs1 and for rs2.

Test Plan:
- addi x5 then add x6,x5,x1 back-to-back -> second instruction in EX has ex_a_sel=10, ex_b_sel=00, stall never high.
- add x5; nop; sub x7,x2,x5 -> sub in EX has ex_b_sel=11. Same pattern with rs1=x0 and EX.rd=x0 -> selects stay 00.
- lw x5; add x6,x5,x5 (LOAD_STALL=1) -> stall=1 for exactly one cycle, then a bubble with ex_valid=0, then add with ex_a_sel=11 and ex_b_sel=11.
- add x5; add x5; sw x5,0(x5) -> sw in EX has ex_a_sel=10, ex_b_sel=01 (imm), ex_st_sel=10 (nearest producer wins).
- lw x5; dependent add with flush asserted in the stall cycle -> stall=0, ex_valid=0 next cycle, FSM returns to RUN.
- rst_n pulsed low during the stall cycle -> all ex_* outputs are 0 immediately; after release, the first instruction proceeds with no stall.
